// File: rtl/ula_div_8b.sv
// Sequential restoring divider for the ULA family: one quotient bit per clock, ALU-style flag bus.
// Optional two's-complement mode is compiled in with `define DIV_SIGNED_EN (selected per division by sgn).
module ula_div_8b #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         sgn,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quociente,
  output logic [W-1:0] resto,
  output logic [3:0]   flag
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   dvd_q, dvd_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [W:0]     rem_q, rem_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           mode_q, mode_d;
  logic           neg_quo_q, neg_quo_d;
  logic           neg_rem_q, neg_rem_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   res_q, res_d;
  logic [3:0]     flag_q, flag_d;

  logic           a_neg, b_neg, sgn_eff;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     rem_shift;
  logic [W+1:0]   diff;
  logic           q_bit;
  logic [W:0]     rem_next;
  logic [W-1:0]   q_mag, r_mag, q_out, r_out;
  logic           ovf;

`ifdef DIV_SIGNED_EN
  assign sgn_eff = sgn;
  assign a_neg   = sgn & A[W-1];
  assign b_neg   = sgn & B[W-1];
`else
  logic unused_sgn;
  assign unused_sgn = sgn;
  assign sgn_eff    = 1'b0;
  assign a_neg      = 1'b0;
  assign b_neg      = 1'b0;
`endif

  assign a_mag = a_neg ? (~A + 1'b1) : A;
  assign b_mag = b_neg ? (~B + 1'b1) : B;

  // The dividend register shifts out its MSB into the remainder and fills with quotient bits,
  // so after W steps it holds the unsigned quotient magnitude.
  assign rem_shift = {rem_q[W-1:0], dvd_q[W-1]};
  assign diff      = {1'b0, rem_shift} - {2'b00, dvs_q};
  assign q_bit     = ~diff[W+1];
  assign rem_next  = q_bit ? diff[W:0] : rem_shift;

  assign q_mag = {dvd_q[W-2:0], q_bit};
  assign r_mag = rem_next[W-1:0];
  assign q_out = neg_quo_q ? (~q_mag + 1'b1) : q_mag;
  assign r_out = neg_rem_q ? (~r_mag + 1'b1) : r_mag;
  // Only most-negative / -1 yields a positive magnitude that does not fit in W signed bits.
  assign ovf   = mode_q & ~neg_quo_q & q_mag[W-1];

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    quo_d     = quo_q;
    res_d     = res_q;
    flag_d    = flag_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d    = sgn_eff;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (B == '0) begin
            state_d = DONE;
            quo_d   = '1;
            res_d   = A;
            flag_d  = 4'b1001;
          end else begin
            state_d = RUN;
            dvd_d   = a_mag;
            dvs_d   = b_mag;
            rem_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      RUN: begin
        dvd_d = q_mag;
        rem_d = rem_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(W - 1)) begin
          state_d = DONE;
          quo_d   = q_out;
          res_d   = r_out;
          flag_d  = {1'b0, ovf, (q_out == '0), q_out[W-1]};
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= '0;
      res_q     <= '0;
      flag_q    <= '0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      quo_q     <= quo_d;
      res_q     <= res_d;
      flag_q    <= flag_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign quociente = quo_q;
  assign resto     = res_q;
  assign flag      = flag_q;

endmodule

// File: tb/tb_ula_div_8b.sv
// Self-checking bench for ula_div_8b: directed cases plus random operands against an arithmetic model.
// Signed cases are exercised only when DIV_SIGNED_EN is defined.
module tb_ula_div_8b;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] A, B;
  logic       sgn;
  logic       busy, done;
  logic [7:0] quociente, resto;
  logic [3:0] flag;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  ula_div_8b #(.W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .sgn(sgn),
    .busy(busy), .done(done), .quociente(quociente), .resto(resto), .flag(flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division; flag = {div0, overflow, zero, negative}
  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic s,
                                output logic [7:0] q, output logic [7:0] r, output logic [3:0] f);
    logic ov;
    int   qi, ri;
    ov = 1'b0;
    if (b == 8'd0) begin
      q = 8'hFF;
      r = a;
      f = {1'b1, 1'b0, (q == 8'd0), q[7]};
      return;
    end
    q = 8'(int'(a) / int'(b));
    r = 8'(int'(a) % int'(b));
`ifdef DIV_SIGNED_EN
    if (s) begin
      qi = int'($signed(a)) / int'($signed(b));
      ri = int'($signed(a)) % int'($signed(b));
      ov = (qi > 127) || (qi < -128);
      q  = qi[7:0];
      r  = ri[7:0];
    end
`else
    qi = int'(s);
    ri = qi;
`endif
    f = {1'b0, ov, (q == 8'd0), q[7]};
  endfunction

  // Launches one division and waits for done; lat counts samples after the accepting edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic s, input bit hold,
                               output int lat, output int busy_cycles, output int done_cyc);
    @(posedge clk); #1;
    A = a; B = b; sgn = s; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    A = 8'($urandom);
    lat = 0;
    busy_cycles = 0;
    while (!done && lat < 30) begin
      if (busy) busy_cycles++;
      @(posedge clk); #1;
      lat++;
    end
    done_cyc = cyc;
  endtask

  task automatic runDiv(input string tag, input logic [7:0] a, input logic [7:0] b, input logic s,
                        input bit hold, output int done_cyc);
    logic [7:0] eq, er;
    logic [3:0] ef;
    int lat, bc;
    model(a, b, s, eq, er, ef);
    applyStimulus(a, b, s, hold, lat, bc, done_cyc);
    checkOutput({tag, ".lat"},  lat, (b == 8'd0) ? 0 : 8);
    checkOutput({tag, ".busycyc"}, bc, (b == 8'd0) ? 0 : 8);
    checkOutput({tag, ".busy_at_done"}, busy, 0);
    checkOutput({tag, ".q"}, quociente, eq);
    checkOutput({tag, ".r"}, resto, er);
    checkOutput({tag, ".flag"}, flag, ef);
  endtask

  initial begin
    int dc, d1, d2, d3, pulses, lat;
    logic [7:0] ra, rb;
    rst = 1'b1; start = 1'b0; A = 8'd0; B = 8'd0; sgn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.done", done, 0);
    checkOutput("reset.q", quociente, 0);
    checkOutput("reset.r", resto, 0);
    checkOutput("reset.flag", flag, 0);
    rst = 1'b0;

    runDiv("basic_100_7", 8'd100, 8'd7, 1'b0, 1'b0, dc);
    checkOutput("basic.flag_const", flag, 4'b0000);

    // Abort mid-RUN: outputs must clear and no done pulse may follow
    @(posedge clk); #1;
    A = 8'd200; B = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort.busy", busy, 0);
    checkOutput("abort.done", done, 0);
    checkOutput("abort.q", quociente, 0);
    checkOutput("abort.r", resto, 0);
    checkOutput("abort.flag", flag, 0);
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    checkOutput("abort.no_activity", pulses, 0);
    runDiv("after_abort_200_3", 8'd200, 8'd3, 1'b0, 1'b0, dc);
    checkOutput("after_abort.q_const", quociente, 8'd66);

    runDiv("zero_q_5_9", 8'd5, 8'd9, 1'b0, 1'b0, dc);
    runDiv("full_255_1", 8'd255, 8'd1, 1'b0, 1'b0, dc);
    runDiv("div0_42_0", 8'd42, 8'd0, 1'b0, 1'b0, dc);
    checkOutput("div0.flag_const", flag, 4'b1001);

    // Start held high: each new division begins on the first IDLE edge after DONE
    runDiv("b2b_100_7", 8'd100, 8'd7, 1'b0, 1'b1, d1);
    runDiv("b2b_81_9", 8'd81, 8'd9, 1'b0, 1'b1, d2);
    runDiv("b2b_13_4", 8'd13, 8'd4, 1'b0, 1'b1, d3);
    start = 1'b0;
    checkOutput("b2b.gap12", d2 - d1, 10);
    checkOutput("b2b.gap23", d3 - d2, 10);

    // Start pulsed during RUN must neither disturb the result nor queue a new division
    @(posedge clk); #1;
    A = 8'd50; B = 8'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    A = 8'd9; B = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 3;
    while (!done && lat < 30) begin @(posedge clk); #1; lat++; end
    checkOutput("ign.lat", lat, 8);
    checkOutput("ign.q", quociente, 8'd10);
    checkOutput("ign.r", resto, 8'd0);
    pulses = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    checkOutput("ign.no_queue", pulses, 0);

`ifdef DIV_SIGNED_EN
    runDiv("s_m7_2", 8'hF9, 8'd2, 1'b1, 1'b0, dc);
    checkOutput("s_m7_2.q_const", quociente, 8'hFD);
    runDiv("s_min_m1", 8'h80, 8'hFF, 1'b1, 1'b0, dc);
    checkOutput("s_min_m1.ovf", flag[2], 1'b1);
    runDiv("s_div0", 8'hF0, 8'd0, 1'b1, 1'b0, dc);
`endif
    runDiv("u_F9_2", 8'hF9, 8'd2, 1'b0, 1'b0, dc);

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = (i % 9 == 0) ? 8'd0 : 8'($urandom);
      runDiv($sformatf("rnd%0d", i), ra, rb, 1'($urandom_range(0, 1)), 1'b0, dc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
